ttt_turn_sequencer: RTL and testbench

//   Game-flow controller for the tic-tac-toe board. Owns the X/O board registers.

---
 rtl/ttt_pkg.sv | 47 ++++
 rtl/ttt_line_checker.sv | 16 +
 rtl/ttt_turn_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ttt_turn_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types, state encoding, win-line masks and square helpers for the
// tic-tac-toe turn sequencer.
package ttt_pkg;

    localparam int unsigned SQ_W      = 4;
    localparam int unsigned NUM_SQ    = 9;
    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned ST_W      = 3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_PLAYER  = 3'd1;
    localparam logic [ST_W-1:0] ST_CHECK_X = 3'd2;
    localparam logic [ST_W-1:0] ST_ENGINE  = 3'd3;
    localparam logic [ST_W-1:0] ST_CHECK_O = 3'd4;
    localparam logic [ST_W-1:0] ST_OVER    = 3'd5;

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_PLAYER  = ST_PLAYER,
        S_CHECK_X = ST_CHECK_X,
        S_ENGINE  = ST_ENGINE,
        S_CHECK_O = ST_CHECK_O,
        S_OVER    = ST_OVER
    } state_e;

    typedef logic [NUM_SQ-1:0] board_t;

    // Rows, columns, then both diagonals; bit i = square i.
    localparam board_t [NUM_LINES-1:0] WIN_LINES = {
        9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
    };

    function automatic board_t sq_mask(input logic [SQ_W-1:0] sq);
        return board_t'(1) << sq;
    endfunction

    // Lowest-index square not set in occ; 0 when the board is full.
    function automatic logic [SQ_W-1:0] lowest_free(input board_t occ);
        logic [SQ_W-1:0] r;
        r = '0;
        for (int i = int'(NUM_SQ) - 1; i >= 0; i--) begin
            if (!occ[i]) r = SQ_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ttt_line_checker.sv
// Combinational three-in-a-row detector for one player's board.
module ttt_line_checker
    import ttt_pkg::*;
(
    input  logic [NUM_SQ-1:0] board_i,
    output logic              has_line_o
);

    always_comb begin
        has_line_o = 1'b0;
        for (int l = 0; l < int'(NUM_LINES); l++) begin
            if ((board_i & WIN_LINES[l]) == WIN_LINES[l]) has_line_o = 1'b1;
        end
    end

endmodule

// File: rtl/ttt_turn_sequencer.sv
// Tic-tac-toe game-flow controller: owns the boards, takes player moves,
// sequences the move engine and holds the result. Optional TTT_SCORE_EN adds score counters.
module ttt_turn_sequencer
    import ttt_pkg::*;
#(
    parameter int unsigned ENGINE_TIMEOUT = 16,
    parameter int unsigned SCORE_W        = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              new_game_i,
    input  logic              player_valid_i,
    input  logic [SQ_W-1:0]   player_square_i,
    output logic              player_ready_o,
    output logic              player_reject_o,
    output logic              eng_req_o,
    output logic [NUM_SQ-1:0] eng_xs_o,
    output logic [NUM_SQ-1:0] eng_os_o,
    input  logic              eng_ack_i,
    input  logic [SQ_W-1:0]   eng_move_i,
    output logic [NUM_SQ-1:0] x_board_o,
    output logic [NUM_SQ-1:0] o_board_o,
    output logic              player_won_o,
    output logic              computer_won_o,
    output logic              game_draw_o
`ifdef TTT_SCORE_EN
    ,
    output logic [SCORE_W-1:0] player_score_o,
    output logic [SCORE_W-1:0] computer_score_o,
    output logic [SCORE_W-1:0] draw_score_o
`endif
);

    localparam int unsigned CNT_W = $clog2(ENGINE_TIMEOUT + 1);

    if (ENGINE_TIMEOUT < 1 || SCORE_W < 1) begin : g_param_check
        $error("ttt_turn_sequencer: ENGINE_TIMEOUT and SCORE_W must be >= 1");
    end

    state_e           state_q;
    board_t           x_q, o_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q, reject_q, req_q;
    logic             pwon_q, cwon_q, draw_q;

    logic   x_line, o_line, full;
    board_t occ, p_mask, e_mask, fb_mask, o_pick_mask;
    logic   p_legal, e_legal, e_fire;
    logic   p_win_c, c_win_c, draw_c;

    ttt_line_checker u_x_line (.board_i(x_q), .has_line_o(x_line));
    ttt_line_checker u_o_line (.board_i(o_q), .has_line_o(o_line));

    // Move legality, fallback selection and result strobes.
    always_comb begin
        occ         = x_q | o_q;
        full        = &occ;
        p_mask      = sq_mask(player_square_i);
        e_mask      = sq_mask(eng_move_i);
        fb_mask     = sq_mask(lowest_free(occ));
        p_legal     = (player_square_i < SQ_W'(NUM_SQ)) && ((occ & p_mask) == '0);
        e_legal     = (eng_move_i < SQ_W'(NUM_SQ)) && ((occ & e_mask) == '0);
        o_pick_mask = (eng_ack_i && e_legal) ? e_mask : fb_mask;
        e_fire      = eng_ack_i || (cnt_q == CNT_W'(ENGINE_TIMEOUT - 1));
        p_win_c     = !new_game_i && (state_q == S_CHECK_X) && x_line;
        c_win_c     = !new_game_i && (state_q == S_CHECK_O) && o_line;
        draw_c      = !new_game_i && full &&
                      (((state_q == S_CHECK_X) && !x_line) ||
                       ((state_q == S_CHECK_O) && !o_line));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            o_q      <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            reject_q <= 1'b0;
            req_q    <= 1'b0;
            pwon_q   <= 1'b0;
            cwon_q   <= 1'b0;
            draw_q   <= 1'b0;
        end else if (new_game_i) begin
            state_q  <= S_PLAYER;
            x_q      <= '0;
            o_q      <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            reject_q <= 1'b0;
            req_q    <= 1'b0;
            pwon_q   <= 1'b0;
            cwon_q   <= 1'b0;
            draw_q   <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_PLAYER;
                    ready_q <= 1'b1;
                end
                S_PLAYER: begin
                    if (player_valid_i) begin
                        if (p_legal) begin
                            x_q     <= x_q | p_mask;
                            ready_q <= 1'b0;
                            state_q <= S_CHECK_X;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                S_CHECK_X: begin
                    if (p_win_c) begin
                        pwon_q  <= 1'b1;
                        state_q <= S_OVER;
                    end else if (draw_c) begin
                        draw_q  <= 1'b1;
                        state_q <= S_OVER;
                    end else begin
                        req_q   <= 1'b1;
                        state_q <= S_ENGINE;
                    end
                end
                S_ENGINE: begin
                    if (e_fire) begin
                        o_q     <= o_q | o_pick_mask;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_CHECK_O;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_CHECK_O: begin
                    if (c_win_c) begin
                        cwon_q  <= 1'b1;
                        state_q <= S_OVER;
                    end else if (draw_c) begin
                        draw_q  <= 1'b1;
                        state_q <= S_OVER;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= S_PLAYER;
                    end
                end
                S_OVER: state_q <= S_OVER;
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef TTT_SCORE_EN
    logic [SCORE_W-1:0] p_score_q, c_score_q, d_score_q;

    // Saturating tallies; survive new_game, cleared only by reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            p_score_q <= '0;
            c_score_q <= '0;
            d_score_q <= '0;
        end else begin
            if (p_win_c && !(&p_score_q)) p_score_q <= p_score_q + SCORE_W'(1);
            if (c_win_c && !(&c_score_q)) c_score_q <= c_score_q + SCORE_W'(1);
            if (draw_c  && !(&d_score_q)) d_score_q <= d_score_q + SCORE_W'(1);
        end
    end

    assign player_score_o   = p_score_q;
    assign computer_score_o = c_score_q;
    assign draw_score_o     = d_score_q;
`endif

    assign player_ready_o  = ready_q;
    assign player_reject_o = reject_q;
    assign eng_req_o       = req_q;
    assign eng_xs_o        = x_q;
    assign eng_os_o        = o_q;
    assign x_board_o       = x_q;
    assign o_board_o       = o_q;
    assign player_won_o    = pwon_q;
    assign computer_won_o  = cwon_q;
    assign game_draw_o     = draw_q;

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Randomized self-checking bench for ttt_turn_sequencer against a game-level
// reference model (board bit-sets, line triples, lowest-free search).
module tb_ttt_turn_sequencer;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned SW      = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       new_game_i = 1'b0;
    logic       player_valid_i = 1'b0;
    logic [3:0] player_square_i = '0;
    logic       player_ready_o, player_reject_o, eng_req_o;
    logic [8:0] eng_xs_o, eng_os_o, x_board_o, o_board_o;
    logic       eng_ack_i = 1'b0;
    logic [3:0] eng_move_i = '0;
    logic       player_won_o, computer_won_o, game_draw_o;
`ifdef TTT_SCORE_EN
    logic [SW-1:0] player_score_o, computer_score_o, draw_score_o;
`endif

    always #5 clock = ~clock;

    ttt_turn_sequencer #(.ENGINE_TIMEOUT(TIMEOUT), .SCORE_W(SW)) dut (
        .clock(clock), .resetn(resetn), .new_game_i(new_game_i),
        .player_valid_i(player_valid_i), .player_square_i(player_square_i),
        .player_ready_o(player_ready_o), .player_reject_o(player_reject_o),
        .eng_req_o(eng_req_o), .eng_xs_o(eng_xs_o), .eng_os_o(eng_os_o),
        .eng_ack_i(eng_ack_i), .eng_move_i(eng_move_i),
        .x_board_o(x_board_o), .o_board_o(o_board_o),
        .player_won_o(player_won_o), .computer_won_o(computer_won_o),
        .game_draw_o(game_draw_o)
`ifdef TTT_SCORE_EN
        , .player_score_o(player_score_o), .computer_score_o(computer_score_o),
        .draw_score_o(draw_score_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit [8:0] xb, ob;
    bit       pw, cw, dr;
    int       ps, cs, ds;
    int       LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                            '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic bit has_line(bit [8:0] b);
        for (int l = 0; l < 8; l++)
            if (b[LN[l][0]] && b[LN[l][1]] && b[LN[l][2]]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int first_free(bit [8:0] occ);
        for (int i = 0; i < 9; i++) if (!occ[i]) return i;
        return -1;
    endfunction

    function automatic bit is_free(int sq);
        if (sq < 0 || sq > 8) return 1'b0;
        return !(xb[sq] || ob[sq]);
    endfunction

    function automatic int sat_inc(int v);
        return (v < (1 << SW) - 1) ? v + 1 : v;
    endfunction

    task automatic check_game(input string tag);
        check({tag, "/x_board"}, 32'(x_board_o), 32'(xb));
        check({tag, "/o_board"}, 32'(o_board_o), 32'(ob));
        check({tag, "/eng_xs"},  32'(eng_xs_o),  32'(xb));
        check({tag, "/eng_os"},  32'(eng_os_o),  32'(ob));
        check({tag, "/flags"},   32'({player_won_o, computer_won_o, game_draw_o}), 32'({pw, cw, dr}));
`ifdef TTT_SCORE_EN
        check({tag, "/scores"},  32'({player_score_o, computer_score_o, draw_score_o}),
              32'({SW'(ps), SW'(cs), SW'(ds)}));
`endif
    endtask

    task automatic model_clear();
        xb = '0; ob = '0; pw = 0; cw = 0; dr = 0;
    endtask

    task automatic new_game_pulse();
        new_game_i = 1'b1;
        step();
        new_game_i = 1'b0;
        model_clear();
        check_game("newgame");
        check("newgame/ready",  32'(player_ready_o),  32'd1);
        check("newgame/req",    32'(eng_req_o),       32'd0);
        check("newgame/reject", 32'(player_reject_o), 32'd0);
    endtask

    // Offer one player move in PLAYER_TURN; on acceptance also run CHECK_X.
    task automatic player_move(input int sq, output bit acc, output bit over);
        bit legal;
        legal = is_free(sq);
        over  = 1'b0;
        acc   = legal;
        check("player/ready_before", 32'(player_ready_o), 32'd1);
        player_valid_i = 1'b1;
        player_square_i = 4'(sq);
        step();
        player_valid_i = 1'b0;
        if (!legal) begin
            check("reject/pulse", 32'(player_reject_o), 32'd1);
            check("reject/ready", 32'(player_ready_o),  32'd1);
            check_game("reject");
            step();
            check("reject/clear", 32'(player_reject_o), 32'd0);
            return;
        end
        xb[sq] = 1'b1;
        check("accept/reject", 32'(player_reject_o), 32'd0);
        check("accept/ready",  32'(player_ready_o),  32'd0);
        check("accept/req_1",  32'(eng_req_o),       32'd0);
        check_game("accept");
        step();
        if (has_line(xb)) begin
            pw = 1; ps = sat_inc(ps); over = 1;
        end else if ((xb | ob) == 9'h1FF) begin
            dr = 1; ds = sat_inc(ds); over = 1;
        end
        check("checkx/req_2", 32'(eng_req_o), 32'(!over));
        check("checkx/ready", 32'(player_ready_o), 32'd0);
        check_game("checkx");
    endtask

    // Service ENGINE_WAIT: ack after wait_cyc cycles, or never (timeout fallback); then CHECK_O.
    task automatic engine_move(input bit ack, input int wait_cyc, input int mv, output bit over);
        bit acked, legal;
        int tgt;
        acked = 1'b0;
        legal = is_free(mv);
        over  = 1'b0;
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            check("engine/req_held", 32'(eng_req_o), 32'd1);
            check("engine/xs_stable", 32'(eng_xs_o), 32'(xb));
            check("engine/os_stable", 32'(eng_os_o), 32'(ob));
            if (ack && k == wait_cyc) begin
                eng_ack_i = 1'b1;
                eng_move_i = 4'(mv);
                step();
                eng_ack_i = 1'b0;
                acked = 1'b1;
                break;
            end
            step();
        end
        tgt = (acked && legal) ? mv : first_free(xb | ob);
        ob[tgt] = 1'b1;
        check("engine/req_drop", 32'(eng_req_o), 32'd0);
        check_game("engine/placed");
        step();
        if (has_line(ob)) begin
            cw = 1; cs = sat_inc(cs); over = 1;
        end else if ((xb | ob) == 9'h1FF) begin
            dr = 1; ds = sat_inc(ds); over = 1;
        end
        check("checko/ready", 32'(player_ready_o), 32'(!over));
        check_game("checko");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, over;
        int sq, guard, r, nfree;
        int frees [9];
        ps = 0; cs = 0; ds = 0;
        model_clear();

        // Reset state.
        step(); step();
        check_game("reset");
        check("reset/ready",  32'(player_ready_o),  32'd0);
        check("reset/req",    32'(eng_req_o),       32'd0);
        check("reset/reject", 32'(player_reject_o), 32'd0);
        resetn = 1'b1;
        step();
        check("idle/ready", 32'(player_ready_o), 32'd1);

        // Centre move, engine answers occupied square -> lowest free.
        player_move(4, acc, over);
        check("dir/x_center", 32'(x_board_o), 32'h010);
        engine_move(1'b1, 2, 4, over);
        check("dir/o_fallback", 32'(o_board_o), 32'h001);
        player_move(4, acc, over);
        player_move(9, acc, over);

        // Engine never answers -> timeout fallback.
        player_move(8, acc, over);
        engine_move(1'b0, 0, 0, over);
        check("dir/o_timeout", 32'(o_board_o), 32'h003);

        // Player wins on the top row.
        new_game_pulse();
        player_move(0, acc, over);
        engine_move(1'b1, 0, 3, over);
        player_move(1, acc, over);
        engine_move(1'b1, 1, 4, over);
        player_move(2, acc, over);
        check("dir/player_won", 32'(player_won_o), 32'd1);
        check("dir/win_over", 32'(over), 32'd1);

        // GAME_OVER ignores offers and acks.
        player_valid_i = 1'b1; player_square_i = 4'd5;
        eng_ack_i = 1'b1; eng_move_i = 4'd6;
        step(); step();
        player_valid_i = 1'b0; eng_ack_i = 1'b0;
        check_game("over/ignore");
        check("over/ready",  32'(player_ready_o),  32'd0);
        check("over/reject", 32'(player_reject_o), 32'd0);
        check("over/req",    32'(eng_req_o),       32'd0);
        new_game_pulse();

        // new_game together with eng_ack in ENGINE_WAIT wins.
        player_move(0, acc, over);
        new_game_i = 1'b1; eng_ack_i = 1'b1; eng_move_i = 4'd4;
        step();
        new_game_i = 1'b0; eng_ack_i = 1'b0;
        model_clear();
        check_game("ng_vs_ack");
        check("ng_vs_ack/req",   32'(eng_req_o),      32'd0);
        check("ng_vs_ack/ready", 32'(player_ready_o), 32'd1);

        // Full board without a line.
        player_move(0, acc, over); engine_move(1'b1, 0, 4, over);
        player_move(2, acc, over); engine_move(1'b1, 3, 1, over);
        player_move(7, acc, over); engine_move(1'b1, 0, 6, over);
        player_move(3, acc, over); engine_move(1'b1, 1, 5, over);
        player_move(8, acc, over);
        check("dir/draw", 32'({player_won_o, computer_won_o, game_draw_o}), 32'b001);

`ifdef TTT_SCORE_EN
        for (int g = 0; g < 16; g++) begin
            new_game_pulse();
            player_move(0, acc, over); engine_move(1'b1, 0, 3, over);
            player_move(1, acc, over); engine_move(1'b1, 0, 4, over);
            player_move(2, acc, over);
        end
        check("score/saturated", 32'(player_score_o), 32'd15);
`endif

        // Randomized games.
        for (int g = 0; g < 30; g++) begin
            new_game_pulse();
            over = 1'b0;
            guard = 0;
            while (!over && guard < 200) begin
                guard++;
                if ($urandom_range(0, 3) == 0) begin
                    sq = int'($urandom_range(0, 15));
                end else begin
                    nfree = 0;
                    for (int i = 0; i < 9; i++) if (is_free(i)) begin frees[nfree] = i; nfree++; end
                    sq = frees[$urandom_range(0, nfree - 1)];
                end
                player_move(sq, acc, over);
                if (acc && !over) begin
                    r = int'($urandom_range(0, 5));
                    if (r == 0) engine_move(1'b0, 0, 0, over);
                    else engine_move(1'b1, int'($urandom_range(0, 4)), int'($urandom_range(0, 10)), over);
                end
            end
            check("random/game_ended", 32'(over), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
